// File: rtl/store_pkg.sv
// Shared store-path definitions: access-size encoding (common with the load
// extender) and the store FSM state type.
package store_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1
  } st_e;

endpackage

// File: rtl/store_lane_align.sv
// Places sized store data and its byte mask onto a two-word lane window
// starting at the byte offset within the first word.
module store_lane_align
  import store_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] data,
  output logic [7:0]  mask8,
  output logic [63:0] data64
);

  logic [3:0]  base;
  logic [31:0] sized_data;

  always_comb begin
    base       = '0;
    sized_data = '0;
    case (size)
      SZ_WORD: begin
        base       = 4'b1111;
        sized_data = data;
      end
      SZ_HALF: begin
        base       = 4'b0011;
        sized_data = {16'h0000, data[15:0]};
      end
      SZ_BYTE: begin
        base       = 4'b0001;
        sized_data = {24'h000000, data[7:0]};
      end
      default: begin
        base       = '0;
        sized_data = '0;
      end
    endcase
    mask8  = {4'b0000, base} << off;
    data64 = {32'h0000_0000, sized_data} << {off, 3'b000};
  end

endmodule

// File: rtl/store_unit.sv
// Store path of the memory stage: accepts SB/SH/SW requests and issues one or
// two byte-enabled word writes, pulsing done on commit or err on illegal size.
module store_unit
  import store_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              done,
  output logic              err
);

  st_e         state;
  logic [7:0]  mask8;
  logic [63:0] data64;
  logic [3:0]  hi_be;
  logic [31:0] hi_wdata;

  store_lane_align u_align (
    .size   (req_size),
    .off    (req_addr[1:0]),
    .data   (req_data),
    .mask8  (mask8),
    .data64 (data64)
  );

  assign req_ready = (state == IDLE);

  // The upper half of the lane window is captured at acceptance so the request
  // inputs are free to change while the beats are outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      hi_be     <= '0;
      hi_wdata  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_size == SZ_ILL) begin
              err <= 1'b1;
            end else begin
              state     <= BEAT0;
              mem_valid <= 1'b1;
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_be    <= mask8[3:0];
              mem_wdata <= data64[31:0];
              hi_be     <= mask8[7:4];
              hi_wdata  <= data64[63:32];
            end
          end
        end
        BEAT0: begin
          if (mem_ready) begin
            if (hi_be != 4'b0000) begin
              state     <= BEAT1;
              mem_addr  <= mem_addr + ADDR_W'(4);
              mem_be    <= hi_be;
              mem_wdata <= hi_wdata;
            end else begin
              state     <= IDLE;
              mem_valid <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        BEAT1: begin
          if (mem_ready) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          mem_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/store_unit.md
# store_unit

Store-path counterpart to the load data extender in the femtoRV32 memory stage. Accepts one SB/SH/SW request per handshake and places the rs2 data onto the correct byte lanes of a 32-bit word-addressed data memory with byte enables. A store that crosses a word boundary is split into two sequential memory write beats. Completion is reported with a one-cycle `done` pulse; an illegal size is reported with a one-cycle `err` pulse.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width of `req_addr` and `mem_addr`.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  1  store request present.
- `req_ready`  out  1  `state==IDLE`; request accepted when `req_valid & req_ready`.
- `req_addr`  in  ADDR_W  byte address of the store.
- `req_data`  in  32  rs2 value; only low 8/16 bits used for SB/SH.
- `req_size`  in  2  `00` word (SW), `01` half (SH), `10` byte (SB), `11` illegal.
- `mem_valid`  out  1  write beat present.
- `mem_ready`  in  1  memory accepts beat when `mem_valid & mem_ready`.
- `mem_addr`  out  ADDR_W  word-aligned address (`[1:0]` always `00`).
- `mem_wdata`  out  32  lane-aligned write data.
- `mem_be`  out  4  byte enables; bit i enables `mem_wdata[8i+7:8i]`.
- `done`  out  1  one-cycle pulse: store fully committed.
- `err`  out  1  one-cycle pulse: illegal `req_size` rejected.

## Operation
- States: IDLE, BEAT0, BEAT1.
- On acceptance, latch `off = req_addr[1:0]`; compute base mask `1111`/`0011`/`0001` for word/half/byte.
- `mask8 = {4'b0, base} << off`; `data64 = {32'b0, sized_data} << (8*off)`, where `sized_data` zero-fills bits above the access size.
- IDLE → BEAT0 on legal acceptance. Drive `mem_addr = {req_addr[ADDR_W-1:2], 2'b00}`, `mem_be = mask8[3:0]`, `mem_wdata = data64[31:0]`.
- BEAT0 → BEAT1 on handshake if `mask8[7:4] != 0`. Drive `mem_addr` + 4 (mod 2^ADDR_W), `mem_be = mask8[7:4]`, `mem_wdata = data64[63:32]`.
- BEAT0 → IDLE on handshake if no upper lanes. BEAT1 → IDLE on handshake.
- Illegal size: accepted and stays in IDLE; no memory beat is issued; `err` pulses next cycle; `done` is not asserted.
- `mem_be` is never `0000` while `mem_valid=1`.

## Timing
- Reset values: state IDLE, `mem_valid=0`, `mem_addr=0`, `mem_wdata=0`, `mem_be=0`, `done=0`, `err=0`. `req_ready` reads 1 during reset, but nothing is accepted while `rst_n=0`.
- All `mem_*` outputs, `done` and `err` are registered. `req_ready` is decoded from state.
- Aligned store, `mem_ready=1`:
  - T: accept.
  - T+1: beat.
  - T+2: `done=1`, and `req_ready=1` (back-to-back accept allowed).
- Split store, `mem_ready=1`: T+1 beat0, T+2 beat1, T+3 `done`.
- `mem_valid` stays high and `mem_addr`/`mem_wdata`/`mem_be` stay stable until handshake. No combinational path from `mem_ready` to any output.
- `req_*` inputs are sampled only at acceptance; later changes are ignored.
- Reset mid-operation: the next beat is abandoned immediately and `mem_valid` drops asynchronously. A completed beat0 is not undone. No `done` is issued.
- Address wrap: beat1 of a store at `2^ADDR_W-2` goes to address 0.

## Structure
- Package `store_pkg` holds:
  - size constants `SZ_WORD=2'b00`, `SZ_HALF=2'b01`, `SZ_BYTE=2'b10`, `SZ_ILL=2'b11`, shared with the load extender's select encoding;
  - state enum `st_e {IDLE, BEAT0, BEAT1}`.
- One combinational sub-module, `store_lane_align`: (`size`, `off`, `data`) → (`mask8[7:0]`, `data64[63:0]`).
- The FSM and the output registers live in `store_unit`.

## Test plan
- SW `0x100`, data `0xDEADBEEF`, `mem_ready=1` → one beat: addr `0x100`, be `1111`, wdata `0xDEADBEEF`; `done` at T+2.
- SB `0x203`, data `0x123456AB` → one beat: addr `0x200`, be `1000`, wdata `0xAB000000`; `done` at T+2.
- SH `0x107`, data `0x0000CAFE` → beat0: addr `0x104`, be `1000`, wdata `0xFE000000`. Beat1: addr `0x108`, be `0001`, wdata `0x000000CA`. `done` at T+3.
- SW `0x102`, data `0x11223344`, `mem_ready` low 3 cycles on beat0 → beat0 held stable: addr `0x100`, be `1100`, wdata `0x33440000`. Then beat1: addr `0x104`, be `0011`, wdata `0x00001122`.
- Size `11` at any address → no `mem_valid`, `err=1` at T+1, `done=0`. Also SW at `0xFFFFFFFE` → beat0 addr `0xFFFFFFFC` be `1100`, then beat1 addr `0x00000000` be `0011`.
- `rst_n` pulsed low while BEAT1 waits on `mem_ready=0` → `mem_valid=0` immediately, all outputs at reset values, no `done`; the next request is accepted normally.
